// File: rtl/unidade_controle_genius.sv
// Genius memory-game control unit: Moore FSM that sequences the datapath counters, move
// register and sequence memory for mode 1 / mode 2 play, with a timer-freezing pause.
module unidade_controle_genius #(
    parameter int unsigned ESTADO_W = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                modo2,
    input  logic                pausa_jogo,
    input  logic                jogada,
    input  logic                jogada_correta,
    input  logic                enderecoIgualRodada,
    input  logic                fimRodada,
    input  logic                fimTM,
    input  logic                timeout,
    output logic                zeraE,
    output logic                contaE,
    output logic                zeraR,
    output logic                contaR,
    output logic                zeraTM,
    output logic                contaTM,
    output logic                zeraTO,
    output logic                contaTO,
    output logic                limpaR,
    output logic                registraR,
    output logic                escreveM,
    output logic                mostra_leds,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                vez_jogador,
    output logic                nova_jogada,
    output logic                jogo_pausado,
    output logic [ESTADO_W-1:0] db_estado
);

    typedef enum logic [ESTADO_W-1:0] {
        StInicial      = 5'h00,
        StPrepara      = 5'h01,
        StIniciaRodada = 5'h02,
        StMostra       = 5'h03,
        StApaga        = 5'h04,
        StProxMostra   = 5'h05,
        StFimMostra    = 5'h06,
        StEsperaJogada = 5'h07,
        StRegistra     = 5'h08,
        StCompara      = 5'h09,
        StProxJogada   = 5'h0A,
        StEsperaGrava  = 5'h0B,
        StGrava        = 5'h0C,
        StGravaMem     = 5'h0D,
        StProxRodada   = 5'h0E,
        StGanhou       = 5'h10,
        StPerdeu       = 5'h11,
        StPausado      = 5'h12
    } estado_e;

    estado_e estado_q, estado_d;
    estado_e ret_q, ret_d;
    logic    modo2_q, modo2_d;
    logic    rodada0_q, rodada0_d;
    logic    pausavel;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= StInicial;
            ret_q     <= StInicial;
            modo2_q   <= 1'b0;
            rodada0_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            ret_q     <= ret_d;
            modo2_q   <= modo2_d;
            rodada0_q <= rodada0_d;
        end
    end

    // Only the in-game states can be frozen; setup and end states ignore the pause.
    assign pausavel = (estado_q >= StIniciaRodada) && (estado_q <= StProxRodada);

    always_comb begin
        estado_d  = estado_q;
        ret_d     = ret_q;
        modo2_d   = modo2_q;
        rodada0_d = rodada0_q;
        if (pausavel && pausa_jogo) begin
            estado_d = StPausado;
            ret_d    = estado_q;
        end else begin
            unique case (estado_q)
                StInicial: if (iniciar) estado_d = StPrepara;
                StPrepara: begin
                    modo2_d   = modo2;
                    rodada0_d = 1'b1;
                    estado_d  = StIniciaRodada;
                end
                StIniciaRodada: estado_d = (!modo2_q || rodada0_q) ? StMostra : StEsperaJogada;
                StMostra:       if (fimTM) estado_d = StApaga;
                StApaga: begin
                    if (fimTM) estado_d = enderecoIgualRodada ? StFimMostra : StProxMostra;
                end
                StProxMostra:   estado_d = StMostra;
                StFimMostra:    estado_d = StEsperaJogada;
                StEsperaJogada: begin
                    if (jogada)       estado_d = StRegistra;
                    else if (timeout) estado_d = StPerdeu;
                end
                StRegistra:     estado_d = StCompara;
                StCompara: begin
                    if (!jogada_correta)           estado_d = StPerdeu;
                    else if (!enderecoIgualRodada) estado_d = StProxJogada;
                    else if (fimRodada)            estado_d = StGanhou;
                    else if (modo2_q)              estado_d = StEsperaGrava;
                    else                           estado_d = StProxRodada;
                end
                StProxJogada:   estado_d = StEsperaJogada;
                StEsperaGrava: begin
                    if (jogada)       estado_d = StGrava;
                    else if (timeout) estado_d = StPerdeu;
                end
                StGrava:        estado_d = StGravaMem;
                StGravaMem:     estado_d = StProxRodada;
                StProxRodada: begin
                    rodada0_d = 1'b0;
                    estado_d  = StIniciaRodada;
                end
                StGanhou, StPerdeu: if (iniciar) estado_d = StPrepara;
                StPausado:      if (!pausa_jogo) estado_d = ret_q;
                default:        estado_d = StInicial;
            endcase
        end
    end

    always_comb begin
        zeraE        = 1'b0;
        contaE       = 1'b0;
        zeraR        = 1'b0;
        contaR       = 1'b0;
        zeraTM       = 1'b0;
        contaTM      = 1'b0;
        zeraTO       = 1'b0;
        contaTO      = 1'b0;
        limpaR       = 1'b0;
        registraR    = 1'b0;
        escreveM     = 1'b0;
        mostra_leds  = 1'b0;
        pronto       = 1'b0;
        ganhou       = 1'b0;
        perdeu       = 1'b0;
        vez_jogador  = 1'b0;
        nova_jogada  = 1'b0;
        jogo_pausado = 1'b0;
        db_estado    = estado_q;
        unique case (estado_q)
            StPrepara: begin
                zeraE  = 1'b1;
                zeraR  = 1'b1;
                zeraTM = 1'b1;
                zeraTO = 1'b1;
                limpaR = 1'b1;
            end
            StIniciaRodada: begin
                zeraE  = 1'b1;
                zeraTM = 1'b1;
                zeraTO = 1'b1;
            end
            StMostra: begin
                mostra_leds = 1'b1;
                contaTM     = 1'b1;
            end
            StApaga:      contaTM = 1'b1;
            StProxMostra: begin
                contaE = 1'b1;
                zeraTM = 1'b1;
            end
            StFimMostra: begin
                zeraE  = 1'b1;
                zeraTO = 1'b1;
            end
            StEsperaJogada: begin
                vez_jogador = 1'b1;
                contaTO     = 1'b1;
            end
            StRegistra: begin
                registraR = 1'b1;
                zeraTO    = 1'b1;
            end
            StProxJogada: contaE = 1'b1;
            StEsperaGrava: begin
                nova_jogada = 1'b1;
                contaTO     = 1'b1;
            end
            // Address steps to round+1 while the new move is captured for GRAVA_MEM.
            StGrava: begin
                contaE    = 1'b1;
                registraR = 1'b1;
            end
            StGravaMem:   escreveM = 1'b1;
            StProxRodada: contaR = 1'b1;
            StGanhou: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            StPerdeu: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            StPausado:    jogo_pausado = 1'b1;
            default: ;
        endcase
    end

endmodule
